// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encoding and channel slice helper for mux_nway_arb.
package mux_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);
  logic any;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = SW'(i);
        any = 1'b1;
      end
    end
    // a request above ptr outranks the wrapped-around lowest request
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i > int'(ptr)) gnt_idx = SW'(i);
    end
    gnt = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: registered N-channel mux with fixed or round-robin grant and valid/ready backpressure.
module mux_nway_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out,
  output logic [SW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [WIDTH-1:0] ch_data [N];
  logic [N-1:0]     rr_gnt, sel_oh, gnt;
  logic [SW-1:0]    rr_idx, idx, ptr;
  logic             can_load, load;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = in_data[slice_lo(i, WIDTH) +: WIDTH];
  end
  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req    (in_valid),
    .ptr    (ptr),
    .gnt    (rr_gnt),
    .gnt_idx(rr_idx)
  );
  // fixed mode offers ready on sel regardless of its valid; a transfer still needs valid
  always_comb begin
    can_load = !out_valid || out_ready;
    sel_oh   = (int'(sel) < N) ? N'(1) << sel : '0;
    gnt      = (mode == MODE_RR) ? rr_gnt : sel_oh;
    idx      = (mode == MODE_RR) ? rr_idx : sel;
    in_ready = can_load ? gnt : '0;
    load     = |(in_valid & in_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= SW'(N - 1);
    end else begin
      if (load) begin
        out    <= ch_data[idx];
        out_ch <= idx;
        ptr    <= idx;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_mux_nway_arb.sv
// tb_mux_nway_arb: directed vectors with a scoreboard queue checked by a negedge output monitor.
module tb_mux_nway_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [15:0] out;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [15:0] d; logic [1:0] ch;} exp_t;
  exp_t q[$];
  mux_nway_arb #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] d, input logic [1:0] ch);
    q.push_back('{d: d, ch: ch});
  endtask
  task automatic cyc(input string name, input logic [3:0] exp_ready);
    #1;
    chk(name, 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h ch %0d expected none", out, out_ch);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out !== e.d || out_ch !== e.ch) begin
          errors++;
          $display("FAIL out_word got %h ch %0d expected %h ch %0d", out, out_ch, e.d, e.ch);
        end
      end
    end
  end
  initial begin
    #2;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_out", 32'(out), 0);
    chk("reset_ch", 32'(out_ch), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // fixed mode, sel stepped 0..3
    mode = 1'b0;
    in_data = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      push(16'h0001 << s, 2'(s));
      cyc("fixed_ready", 4'b0001 << s);
    end
    idle();
    // round-robin, all valid
    mode = 1'b1;
    in_data = {16'h00d3, 16'h00c2, 16'h00b1, 16'h00a0};
    in_valid = 4'b1111;
    push(16'h00a0, 2'd0); cyc("rr_all_ready0", 4'b0001);
    push(16'h00b1, 2'd1); cyc("rr_all_ready1", 4'b0010);
    push(16'h00c2, 2'd2); cyc("rr_all_ready2", 4'b0100);
    push(16'h00d3, 2'd3); cyc("rr_all_ready3", 4'b1000);
    push(16'h00a0, 2'd0); cyc("rr_all_ready4", 4'b0001);
    idle();
    // round-robin sparse: ch1/ch3, then ch2 joins after a ch1 transfer
    in_valid = 4'b1010;
    push(16'h00b1, 2'd1); cyc("rr_sparse_1a", 4'b0010);
    push(16'h00d3, 2'd3); cyc("rr_sparse_3", 4'b1000);
    push(16'h00b1, 2'd1); cyc("rr_sparse_1b", 4'b0010);
    in_valid = 4'b1110;
    push(16'h00c2, 2'd2); cyc("rr_sparse_2", 4'b0100);
    idle();
    // backpressure with 0004 held for three cycles
    mode = 1'b0;
    sel = 2'd2;
    out_ready = 1'b0;
    in_data = {16'h0000, 16'h0004, 16'h0000, 16'h0000};
    in_valid = 4'b0100;
    push(16'h0004, 2'd2); cyc("bp_load_ready", 4'b0100);
    in_data = {16'h0000, 16'h0005, 16'h0000, 16'h0000};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_out", 32'(out), 32'h0004);
      chk("bp_hold_valid", 32'(out_valid), 1);
      cyc("bp_ready_zero", 4'b0000);
    end
    out_ready = 1'b1;
    push(16'h0005, 2'd2); cyc("bp_release_ready", 4'b0100);
    idle();
    // mode switch: pointer follows fixed-mode transfers
    mode = 1'b1;
    in_data = {16'h00d3, 16'h00c2, 16'h00b1, 16'h00a0};
    in_valid = 4'b0100;
    push(16'h00c2, 2'd2); cyc("ms_rr_ch2", 4'b0100);
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b1111;
    push(16'h00a0, 2'd0); cyc("ms_fixed_ch0", 4'b0001);
    mode = 1'b1;
    push(16'h00b1, 2'd1); cyc("ms_rr_ch1", 4'b0010);
    idle();
    // async reset drops a held word
    out_ready = 1'b0;
    in_valid = 4'b1111;
    cyc("pre_reset_ready", 4'b0100);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_ch", 32'(out_ch), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    push(16'h00a0, 2'd0); cyc("post_reset_ch0", 4'b0001);
    idle();
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
